// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/redirect controller.
package pipe_ctrl_pkg;

    typedef logic        bit_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
    } stall_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXC_PEND = 2'd1,
        ST_BR_PEND  = 2'd2
    } pipe_ctrl_state_t;

    localparam stall_t STALL_NONE = '0;

endpackage

// File: rtl/pipe_stall_merge.sv
// Merges per-stage stall requests into the stall vector; a later stage
// stalling freezes every earlier stage. A flush cycle forces all zeros.
module pipe_stall_merge
    import pipe_ctrl_pkg::*;
(
    input  logic   i_req_if,
    input  logic   i_req_id,
    input  logic   i_req_ex,
    input  logic   i_req_mem,
    input  logic   i_flush,
    output stall_t o_stall_raw,
    output stall_t o_stall
);

    stall_t w_raw;

    always_comb begin
        w_raw           = STALL_NONE;
        w_raw.stall_mem = i_req_mem;
        w_raw.stall_ex  = i_req_mem | i_req_ex;
        w_raw.stall_id  = i_req_mem | i_req_ex | i_req_id;
        w_raw.stall_if  = i_req_mem | i_req_ex | i_req_id | i_req_if;
    end

    assign o_stall_raw = w_raw;
    assign o_stall     = i_flush ? STALL_NONE : w_raw;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller: merges stall requests, issues
// exception flushes and sequences PC redirects, deferring them when blocked.
//
// state       | meaning
// ST_IDLE     | nothing held; exceptions/mispredicts handled same cycle
// ST_EXC_PEND | exception target held until the dcache stall clears
// ST_BR_PEND  | mispredict target held until fetch is no longer stalled
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    parameter int PERF_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              except_valid,
    input  logic [ADDR_W-1:0] except_target,
    input  logic              mispredict_valid,
    input  logic [ADDR_W-1:0] mispredict_target,
    output stall_t            stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              pend_busy,
    output logic [CNT_W-1:0]  perf_stall_cycles
);

    pipe_ctrl_state_t  r_state;
    pipe_ctrl_state_t  w_state_nxt;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_target_nxt;
    logic              w_flush;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_pc;
    stall_t            w_stall_raw;
    stall_t            w_stall;

    pipe_stall_merge u_merge (
        .i_req_if    (stallreq_if),
        .i_req_id    (stallreq_id),
        .i_req_ex    (stallreq_ex),
        .i_req_mem   (stallreq_mem),
        .i_flush     (w_flush),
        .o_stall_raw (w_stall_raw),
        .o_stall     (w_stall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_flush       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        case (r_state)
            // A pending branch is discarded by an exception, so both states share this path.
            ST_IDLE, ST_BR_PEND: begin
                if (except_valid) begin
                    if (!stallreq_mem) begin
                        w_flush       = 1'b1;
                        w_redirect    = 1'b1;
                        w_redirect_pc = except_target;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_target_nxt = except_target;
                        w_state_nxt  = ST_EXC_PEND;
                    end
                end else if (mispredict_valid) begin
                    if (!w_stall_raw.stall_if) begin
                        w_redirect    = 1'b1;
                        w_redirect_pc = mispredict_target;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_target_nxt = mispredict_target;
                        w_state_nxt  = ST_BR_PEND;
                    end
                end else if (r_state == ST_BR_PEND && !w_stall_raw.stall_if) begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_target;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_EXC_PEND: begin
                if (!stallreq_mem) begin
                    w_flush       = 1'b1;
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_target;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign stall          = w_stall;
    assign flush          = w_flush;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_redirect_pc;
    assign pend_busy      = (r_state != ST_IDLE);

    generate
        if (PERF_EN != 0) begin : g_perf
            logic [CNT_W-1:0] r_perf;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_perf <= '0;
                end else if (w_stall.stall_if) begin
                    r_perf <= r_perf + 1'b1;
                end
            end
            assign perf_stall_cycles = r_perf;
        end else begin : g_no_perf
            assign perf_stall_cycles = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario stimulus tables, expected
// outputs queued on drive and popped/compared at the following negedge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        except_valid, mispredict_valid;
    word_t       except_target, mispredict_target;
    stall_t      stall;
    logic        flush, redirect_valid, pend_busy;
    word_t       redirect_pc;
    logic [31:0] perf_stall_cycles;

    typedef struct packed {
        logic [4:0]  st;
        logic        fl;
        logic        rv;
        logic [31:0] pc;
        logic        busy;
    } obs_t;

    typedef struct packed {
        logic [3:0]  req;   // {if, id, ex, mem}
        logic        exc;
        logic [31:0] et;
        logic        mis;
        logic [31:0] mt;
        obs_t        exp;
    } stim_t;

    obs_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(32), .PERF_EN(1)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_if       (stallreq_if),
        .stallreq_id       (stallreq_id),
        .stallreq_ex       (stallreq_ex),
        .stallreq_mem      (stallreq_mem),
        .except_valid      (except_valid),
        .except_target     (except_target),
        .mispredict_valid  (mispredict_valid),
        .mispredict_target (mispredict_target),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pend_busy         (pend_busy),
        .perf_stall_cycles (perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic [3:0] req, logic exc, logic [31:0] et,
                                 logic mis, logic [31:0] mt, logic [4:0] st,
                                 logic fl, logic rv, logic [31:0] pc, logic busy);
        stim_t s;
        s.req = req; s.exc = exc; s.et = et; s.mis = mis; s.mt = mt;
        s.exp.st = st; s.exp.fl = fl; s.exp.rv = rv; s.exp.pc = pc; s.exp.busy = busy;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = stall; o.fl = flush; o.rv = redirect_valid;
        o.pc = redirect_pc; o.busy = pend_busy;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = s.req;
        except_valid      = s.exc;
        except_target     = s.et;
        mispredict_valid  = s.mis;
        mispredict_target = s.mt;
        sb.push_back(s.exp);
    endtask

    task automatic idle_inputs();
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
        except_valid = 1'b0; except_target = '0;
        mispredict_valid = 1'b0; mispredict_target = '0;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0;
        idle_inputs();
        #3;
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, obs_t'(0));
        end
        n_cmp++;
        if (perf_stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_stall_cycles);
        end
        #5 rst = 1'b1;
    endtask

    task automatic test_stall_merge();
        stim_t t[$];
        obs_t e, got;
        t.push_back(mk(4'b0010, 0, 0, 0, 0, 5'b11100, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0100, 0, 0, 0, 0, 5'b11000, 0, 0, 0, 0));
        t.push_back(mk(4'b1000, 0, 0, 0, 0, 5'b10000, 0, 0, 0, 0));
        t.push_back(mk(4'b0001, 0, 0, 0, 0, 5'b11110, 0, 0, 0, 0));
        t.push_back(mk(4'b1111, 0, 0, 0, 0, 5'b11110, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL stall_merge[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_exc_immediate();
        stim_t t[$];
        obs_t e, got;
        t.push_back(mk(4'b0000, 1, 32'hBFC00380, 0, 0, 5'b00000, 1, 1, 32'hBFC00380, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0010, 1, 32'h80000180, 0, 0, 5'b00000, 1, 1, 32'h80000180, 0));
        t.push_back(mk(4'b1000, 1, 32'h80000200, 0, 0, 5'b00000, 1, 1, 32'h80000200, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL exc_immediate[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_exc_pending();
        stim_t t[$];
        obs_t e, got;
        t.push_back(mk(4'b0001, 1, 32'h80000180, 0, 0, 5'b11110, 0, 0, 0, 0));
        t.push_back(mk(4'b0001, 0, 0, 0, 0, 5'b11110, 0, 0, 0, 1));
        t.push_back(mk(4'b0001, 1, 32'hBFC00380, 1, 32'h80001000, 5'b11110, 0, 0, 0, 1));
        t.push_back(mk(4'b0001, 0, 0, 0, 0, 5'b11110, 0, 0, 0, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 1, 1, 32'h80000180, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL exc_pending[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_branch();
        stim_t t[$];
        obs_t e, got;
        // deferred mispredict overwritten by a second one
        t.push_back(mk(4'b1000, 0, 0, 1, 32'h80001000, 5'b10000, 0, 0, 0, 0));
        t.push_back(mk(4'b1000, 0, 0, 1, 32'h80002000, 5'b10000, 0, 0, 0, 1));
        t.push_back(mk(4'b1000, 0, 0, 0, 0, 5'b10000, 0, 0, 0, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 1, 32'h80002000, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        // immediate mispredict
        t.push_back(mk(4'b0000, 0, 0, 1, 32'h80003000, 5'b00000, 0, 1, 32'h80003000, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        // exception discards pending branch (immediate flush)
        t.push_back(mk(4'b1000, 0, 0, 1, 32'h80004000, 5'b10000, 0, 0, 0, 0));
        t.push_back(mk(4'b1000, 1, 32'hBFC00380, 0, 0, 5'b00000, 1, 1, 32'hBFC00380, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        // exception discards pending branch (deferred behind mem stall)
        t.push_back(mk(4'b0001, 0, 0, 1, 32'h80005000, 5'b11110, 0, 0, 0, 0));
        t.push_back(mk(4'b0001, 1, 32'h80000180, 0, 0, 5'b11110, 0, 0, 0, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 1, 1, 32'h80000180, 1));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL branch[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t t[$];
        obs_t e, got;
        t.push_back(mk(4'b0000, 1, 32'hBFC00380, 1, 32'h80001000, 5'b00000, 1, 1, 32'hBFC00380, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL simultaneous[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_pending_and_perf();
        stim_t t[$];
        obs_t e, got;
        t.push_back(mk(4'b0001, 1, 32'h80000180, 0, 0, 5'b11110, 0, 0, 0, 0));
        t.push_back(mk(4'b0001, 0, 0, 0, 0, 5'b11110, 0, 0, 0, 1));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL rst_pend_setup[%0d]: got %h expected %h", i, got, e);
            end
        end
        #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_fail++; $display("FAIL rst_pend_async: got %h expected %h", got, obs_t'(0));
        end
        n_cmp++;
        if (perf_stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL rst_pend_perf: got %0d expected 0", perf_stall_cycles);
        end
        @(negedge clk);
        rst = 1'b1;
        t.delete();
        for (int k = 0; k < 5; k++)
            t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++)
            t.push_back(mk(4'b1000, 0, 0, 0, 0, 5'b10000, 0, 0, 0, 0));
        t.push_back(mk(4'b0000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front(); got = sample();
            n_cmp++;
            if (got !== e) begin
                n_fail++; $display("FAIL post_reset[%0d]: got %h expected %h", i, got, e);
            end
        end
        n_cmp++;
        if (perf_stall_cycles !== 32'd7) begin
            n_fail++; $display("FAIL perf_count: got %0d expected 7", perf_stall_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall_merge();
        test_exc_immediate();
        test_exc_pending();
        test_branch();
        test_simultaneous();
        test_reset_pending_and_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
